bullet_ctrl: RTL and testbench
==============================

BULLET_CTRL -- requirements
Module: bullet_ctrl

Interface
REQ-001 Parameter NSLOT, default 4: number of bullet slots, range 1..8.
REQ-002 Parameter SPEED, default 4: pixels a bullet moves up per frame.
REQ-003 Parameter R, default 12: bullet radius in pixels, used for the top-edge retire test.
REQ-004 clk  in  1  single system clock; all state changes on its rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 frame_tick  in  1  one-cycle pulse, once per video frame; starts a movement pass.
REQ-007 fire  in  1  one-cycle fire request pulse.
REQ-008 gun_x  in  11  x spawn position, sampled at allocation.
REQ-009 gun_y  in  10  y spawn position, sampled at allocation.
REQ-010 clr  in  1  synchronous clear of all slots.
REQ-011 bx  out  NSLOT*11  packed slot x positions; slot i at bits [11i+10:11i].
REQ-012 by  out  NSLOT*10  packed slot y positions; slot i at bits [10i+9:10i].
REQ-013 active  out  NSLOT  bit i high when slot i holds a live bullet.
REQ-014 fire_ack  out  1  one-cycle pulse: the request was placed in a slot.
REQ-015 fire_drop  out  1  one-cycle pulse: the request was discarded because no slot was free.
REQ-016 update_done  out  1  one-cycle pulse: the movement pass has completed.
REQ-017 frame_overrun  out  1  one-cycle pulse: frame_tick arrived while a pass was still running.

Function
REQ-018 The FSM SHALL have two states, IDLE and MOVE, and a slot index idx of width ceil(log2(NSLOT)), minimum 1 bit.
REQ-019 A fire pulse SHALL set the pending flag at the same edge; a fire pulse while pending is already set SHALL be merged and produce no extra ack or drop.
REQ-020 In IDLE, with pending set and frame_tick low, the controller SHALL do the following at one edge:
- Allocate the lowest-index slot with active=0.
- Load x=gun_x and y=gun_y into that slot.
- Set its active bit.
- Clear pending.
- Assert fire_ack for the next cycle.
REQ-021 If no slot is free under REQ-020, the controller SHALL clear pending and pulse fire_drop instead, with no slot changed.
REQ-022 Fire latency: for a fire pulse sampled at edge k while in IDLE with no tick, the slot is written and fire_ack goes high at edge k+1, for one cycle.
REQ-023 frame_tick sampled in IDLE SHALL move the FSM to MOVE with idx=0; frame_tick has priority over pending fire in the same cycle.
REQ-024 In MOVE, one slot SHALL be processed per edge, slot idx. If active and y < SPEED+R, clear active; if active otherwise, y <= y-SPEED; if inactive, no change.
REQ-025 After processing idx=NSLOT-1, the FSM SHALL return to IDLE and pulse update_done for one cycle.
- A tick at edge k gives update_done high after edge k+NSLOT.
REQ-026 Pending fire SHALL be held during MOVE and serviced on the first IDLE edge without a tick.
REQ-027 frame_tick during MOVE SHALL be ignored for movement and SHALL pulse frame_overrun for one cycle.
REQ-028 Subtraction SHALL be unsigned 10-bit; REQ-024 guarantees it never wraps below 0.
REQ-029 x SHALL never change after allocation.
REQ-030 Slot x/y of inactive slots SHALL retain their last values; consumers gate on active.
REQ-031 clr SHALL do the following at the next edge, in any state:
- Clear all active bits and pending.
- Force IDLE and idx=0.
- Suppress that cycle's ack, drop, done and overrun pulses.
REQ-032 All pulse outputs SHALL be registered, with no combinational path from any input.

Reset
REQ-033 While rst is high, independent of clk, the block SHALL hold the following:
- state=IDLE, idx=0, pending=0.
- active=0, all bx=0, all by=0.
- fire_ack=0, fire_drop=0, update_done=0, frame_overrun=0.
REQ-034 Deassertion mid-pass SHALL leave the block in IDLE with no pass resumed and no fire serviced.

Verification
REQ-035 fire with gun_x=320, gun_y=400 in IDLE -> the next cycle shows active=0001, slot0 x=320 y=400, and fire_ack for one cycle.
REQ-036 slot0 at y=400, frame_tick -> after 4 cycles slot0 y=396 and update_done pulses at tick+4.
REQ-037 slot0 at y=15, frame_tick -> slot0 retires (15<16) and active bit0=0; at y=16 the slot moves to 12 and stays active.
REQ-038 4 slots live, fire -> fire_drop pulses, active stays 1111, no slot changes.
REQ-039 fire one cycle after frame_tick -> fire_ack is delayed until after update_done; a second tick mid-pass pulses frame_overrun.
REQ-040 rst asserted mid-MOVE with 2 slots live -> all outputs 0 immediately and IDLE after release; clr gives the same slot result synchronously.

Source files
------------

// File: rtl/bullet_ctrl.sv
// Bullet slot controller: allocates fired bullets into a fixed pool of slots
// and, once per video frame, walks the pool one slot per clock moving each
// live bullet upward and retiring those that reach the top edge.
module bullet_ctrl #(
  parameter int NSLOT = 4,
  parameter int SPEED = 4,
  parameter int R     = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic               fire,
  input  logic [10:0]        gun_x,
  input  logic [9:0]         gun_y,
  input  logic               clr,
  output logic [NSLOT*11-1:0] bx,
  output logic [NSLOT*10-1:0] by,
  output logic [NSLOT-1:0]   active,
  output logic               fire_ack,
  output logic               fire_drop,
  output logic               update_done,
  output logic               frame_overrun
);

  localparam int             IW         = (NSLOT > 1) ? $clog2(NSLOT) : 1;
  localparam logic [IW-1:0]  LAST       = IW'(NSLOT - 1);
  localparam logic [10:0]    RETIRE_LIM = 11'(SPEED + R);
  localparam logic [9:0]     STEP       = 10'(SPEED);

  // A bullet whose y is this close to the top would cross the edge on its
  // next move, so it is retired instead of moved; this also keeps the
  // unsigned subtraction below from ever wrapping.
  function automatic logic at_top_edge(input logic [9:0] y);
    return {1'b0, y} < RETIRE_LIM;
  endfunction

  function automatic logic [9:0] step_up(input logic [9:0] y);
    return y - STEP;
  endfunction

  typedef enum logic {
    IDLE = 1'b0,
    MOVE = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              pending_q, pending_d;
  logic [NSLOT-1:0]  active_q, active_d;
  logic [10:0]       x_q [NSLOT];
  logic [9:0]        y_q [NSLOT];

  logic              free_any;
  logic [IW-1:0]     free_idx;
  logic              load_en;
  logic              step_en;
  logic              ack_d, drop_d, done_d, ovr_d;

  // Lowest-index free slot; scanning downward lets the lowest index win.
  always_comb begin
    free_any = 1'b0;
    free_idx = '0;
    for (int i = NSLOT - 1; i >= 0; i--) begin
      if (!active_q[i]) begin
        free_any = 1'b1;
        free_idx = IW'(i);
      end
    end
  end

  // Next-state, slot-update strobes and pulse requests for the controller.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pending_d = pending_q | fire;   // a fire while already pending merges
    active_d  = active_q;
    load_en   = 1'b0;
    step_en   = 1'b0;
    ack_d     = 1'b0;
    drop_d    = 1'b0;
    done_d    = 1'b0;
    ovr_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (frame_tick) begin
          // Movement pass wins over a waiting fire; the fire stays pending.
          state_d = MOVE;
          idx_d   = '0;
        end else if (pending_q) begin
          pending_d = 1'b0;
          if (free_any) begin
            load_en            = 1'b1;
            active_d[free_idx] = 1'b1;
            ack_d              = 1'b1;
          end else begin
            drop_d = 1'b1;
          end
        end
      end

      MOVE: begin
        ovr_d = frame_tick;
        if (active_q[idx_q]) begin
          if (at_top_edge(y_q[idx_q])) begin
            active_d[idx_q] = 1'b0;
          end else begin
            step_en = 1'b1;
          end
        end
        if (idx_q == LAST) begin
          state_d = IDLE;
          idx_d   = '0;
          done_d  = 1'b1;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end

      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase

    // Clear overrides everything: empty pool, back to IDLE, no pulses.
    if (clr) begin
      state_d   = IDLE;
      idx_d     = '0;
      pending_d = 1'b0;
      active_d  = '0;
      load_en   = 1'b0;
      step_en   = 1'b0;
      ack_d     = 1'b0;
      drop_d    = 1'b0;
      done_d    = 1'b0;
      ovr_d     = 1'b0;
    end
  end

  // Controller state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      pending_q <= 1'b0;
      active_q  <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      active_q  <= active_d;
    end
  end

  // Slot positions: x is written only on allocation, y on allocation or move.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NSLOT; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
      end
    end else begin
      if (load_en) begin
        x_q[free_idx] <= gun_x;
        y_q[free_idx] <= gun_y;
      end
      if (step_en) begin
        y_q[idx_q] <= step_up(y_q[idx_q]);
      end
    end
  end

  // Registered one-cycle status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fire_ack      <= 1'b0;
      fire_drop     <= 1'b0;
      update_done   <= 1'b0;
      frame_overrun <= 1'b0;
    end else begin
      fire_ack      <= ack_d;
      fire_drop     <= drop_d;
      update_done   <= done_d;
      frame_overrun <= ovr_d;
    end
  end

  assign active = active_q;

  for (genvar g = 0; g < NSLOT; g++) begin : g_pack
    assign bx[g*11 +: 11] = x_q[g];
    assign by[g*10 +: 10] = y_q[g];
  end

endmodule

// File: tb/tb_bullet_ctrl.sv
// Testbench for bullet_ctrl: directed scenarios followed by random traffic,
// checked through a scoreboard fed by a frame-level reference model.
module tb_bullet_ctrl;

  localparam int NSLOT = 4;
  localparam int SPEED = 4;
  localparam int R     = 12;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                frame_tick = 1'b0;
  logic                fire = 1'b0;
  logic                clr = 1'b0;
  logic [10:0]         gun_x = '0;
  logic [9:0]          gun_y = '0;
  logic [NSLOT*11-1:0] bx;
  logic [NSLOT*10-1:0] by;
  logic [NSLOT-1:0]    active;
  logic                fire_ack, fire_drop, update_done, frame_overrun;

  bullet_ctrl #(.NSLOT(NSLOT), .SPEED(SPEED), .R(R)) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .fire(fire),
    .gun_x(gun_x), .gun_y(gun_y), .clr(clr),
    .bx(bx), .by(by), .active(active),
    .fire_ack(fire_ack), .fire_drop(fire_drop),
    .update_done(update_done), .frame_overrun(frame_overrun)
  );

  always #5 clk = ~clk;

  longint ecount = 0;
  always @(posedge clk) ecount <= ecount + 1;

  typedef struct {
    longint              edge_n;
    logic [3:0]          vec;    // {overrun, done, drop, ack}
    logic [NSLOT-1:0]    act;
    logic [NSLOT*11-1:0] bxe;
    logic [NSLOT*10-1:0] bye;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Reference model: bullet pool plus the edge window of the current pass.
  bit     m_act[NSLOT];
  int     m_x[NSLOT];
  int     m_y[NSLOT];
  bit     m_pend;
  longint pass_start, pass_end;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, got, want, ecount);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NSLOT; i++) begin
      m_act[i] = 1'b0;
      m_x[i]   = 0;
      m_y[i]   = 0;
    end
    m_pend     = 1'b0;
    pass_start = 0;
    pass_end   = 0;
  endfunction

  function automatic exp_t snap(input longint n, input logic [3:0] v);
    exp_t e;
    e.edge_n = n;
    e.vec    = v;
    for (int i = 0; i < NSLOT; i++) begin
      e.act[i]          = m_act[i];
      e.bxe[i*11 +: 11] = 11'(m_x[i]);
      e.bye[i*10 +: 10] = 10'(m_y[i]);
    end
    return e;
  endfunction

  // Advance the model over clock edge n with the inputs sampled there.
  // The controller is busy from the tick edge through pass_end; slot s is
  // moved on edge pass_start+1+s and the pass finishes on pass_end.
  task automatic model_step(input longint n, input bit tk, input bit fr,
                            input logic [10:0] gx, input logic [9:0] gy,
                            input bit cl, input bit fc);
    logic [3:0] vec;
    bit         svc;
    bit         found;
    int         s;
    vec = 4'b0000;
    svc = 1'b0;
    if (cl) begin
      for (int i = 0; i < NSLOT; i++) m_act[i] = 1'b0;
      m_pend   = 1'b0;
      pass_end = n;
    end else begin
      if (n > pass_end) begin
        if (tk) begin
          pass_start = n;
          pass_end   = n + NSLOT;
        end else if (m_pend) begin
          svc    = 1'b1;
          m_pend = 1'b0;
          found  = 1'b0;
          for (int i = 0; i < NSLOT; i++) begin
            if (!found && !m_act[i]) begin
              found    = 1'b1;
              m_act[i] = 1'b1;
              m_x[i]   = int'(gx);
              m_y[i]   = int'(gy);
            end
          end
          vec = found ? 4'b0001 : 4'b0010;
        end
      end else begin
        s = int'(n - pass_start - 1);
        if (m_act[s]) begin
          if (m_y[s] < SPEED + R) m_act[s] = 1'b0;
          else                    m_y[s]   = m_y[s] - SPEED;
        end
        if (tk)            vec[3] = 1'b1;
        if (n == pass_end) vec[2] = 1'b1;
      end
      if (fr && !svc) m_pend = 1'b1;
    end
    if (vec != 4'b0000 || cl || fc) sbq.push_back(snap(n, vec));
  endtask

  task automatic drive(input bit tk, input bit fr, input logic [10:0] gx,
                       input logic [9:0] gy, input bit cl, input bit fc);
    @(negedge clk);
    frame_tick = tk;
    fire       = fr;
    gun_x      = gx;
    gun_y      = gy;
    clr        = cl;
    model_step(ecount + 1, tk, fr, gx, gy, cl, fc);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, gun_x, gun_y, 1'b0, 1'b0);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2;
    rst        = 1'b1;
    frame_tick = 1'b0;
    fire       = 1'b0;
    clr        = 1'b0;
    #1;
    check("rst_async_active", active, 0);
    check("rst_async_bx", bx, 0);
    check("rst_async_by", by, 0);
    check("rst_async_pulses", {frame_overrun, update_done, fire_drop, fire_ack}, 0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Scoreboard monitor: every expected entry is due at a specific edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      while (sbq.size() > 0 && sbq[0].edge_n < ecount) begin
        check("sb_missed_edge", ecount, sbq[0].edge_n);
        void'(sbq.pop_front());
      end
      if (sbq.size() > 0 && sbq[0].edge_n == ecount) begin
        mon_e = sbq.pop_front();
        check("sb_pulses", {frame_overrun, update_done, fire_drop, fire_ack}, mon_e.vec);
        check("sb_active", active, mon_e.act);
        check("sb_bx", bx, mon_e.bxe);
        check("sb_by", by, mon_e.bye);
      end else if ({frame_overrun, update_done, fire_drop, fire_ack} != 4'b0000) begin
        check("sb_unexpected_pulse", {frame_overrun, update_done, fire_drop, fire_ack}, 0);
      end
    end
  end

  initial begin
    bit tk, fr, cl, fc;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_active", active, 0);
    check("reset_bx", bx, 0);
    check("reset_by", by, 0);
    check("reset_pulses", {frame_overrun, update_done, fire_drop, fire_ack}, 0);
    @(negedge clk);
    rst = 1'b0;

    // Single fire from (320,400).
    drive(1'b0, 1'b1, 11'd320, 10'd400, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 11'd320, 10'd400, 1'b0, 1'b0);
    after_edge();
    check("fire_ack_pulse", fire_ack, 1);
    check("alloc_active", active, 4'b0001);
    check("alloc_x", bx[10:0], 320);
    check("alloc_y", by[9:0], 400);
    idle(1);
    after_edge();
    check("fire_ack_one_cycle", fire_ack, 0);

    // One movement pass.
    drive(1'b1, 1'b0, gun_x, gun_y, 1'b0, 1'b0);
    idle(4);
    after_edge();
    check("done_at_tick_plus_n", update_done, 1);
    check("move_y", by[9:0], 396);

    // Retire boundary: y=15 retires, y=16 moves to 12.
    drive(1'b0, 1'b1, 11'd300, 10'd15, 1'b0, 1'b0);
    idle(1);
    drive(1'b0, 1'b1, 11'd100, 10'd16, 1'b0, 1'b0);
    idle(1);
    drive(1'b1, 1'b0, gun_x, gun_y, 1'b0, 1'b0);
    idle(4);
    after_edge();
    check("retire_active", active, 4'b0101);
    check("edge_y16_moves", by[29:20], 12);
    check("slot0_second_move", by[9:0], 392);

    // Fill the pool, then a fire with no free slot.
    drive(1'b0, 1'b1, 11'd500, 10'd500, 1'b0, 1'b0);
    idle(1);
    drive(1'b0, 1'b1, 11'd600, 10'd600, 1'b0, 1'b0);
    idle(1);
    drive(1'b0, 1'b1, 11'd700, 10'd700, 1'b0, 1'b0);
    idle(1);
    after_edge();
    check("drop_pulse", fire_drop, 1);
    check("drop_full_active", active, 4'b1111);
    check("drop_no_ack", fire_ack, 0);

    // Fire just after a tick, second tick mid-pass.
    drive(1'b1, 1'b0, gun_x, gun_y, 1'b0, 1'b0);
    drive(1'b0, 1'b1, gun_x, gun_y, 1'b0, 1'b0);
    drive(1'b1, 1'b0, gun_x, gun_y, 1'b0, 1'b0);
    after_edge();
    check("overrun_pulse", frame_overrun, 1);
    idle(2);
    after_edge();
    check("deferred_done", update_done, 1);
    check("ack_held_during_pass", fire_ack, 0);
    idle(1);
    after_edge();
    check("ack_after_done", fire_ack, 1);
    check("ack_reuses_retired_slot", active, 4'b1111);

    // Synchronous clear from a full pool.
    drive(1'b0, 1'b0, gun_x, gun_y, 1'b1, 1'b1);
    after_edge();
    check("clr_active", active, 0);

    // Clear in the middle of a pass with two live slots.
    drive(1'b0, 1'b1, 11'd50, 10'd200, 1'b0, 1'b0);
    idle(1);
    drive(1'b0, 1'b1, 11'd60, 10'd300, 1'b0, 1'b0);
    idle(1);
    drive(1'b1, 1'b0, gun_x, gun_y, 1'b0, 1'b0);
    idle(1);
    drive(1'b0, 1'b0, gun_x, gun_y, 1'b1, 1'b1);
    after_edge();
    check("clr_mid_move_active", active, 0);
    idle(6);

    // Reset in the middle of a pass with two live slots and a pending fire.
    drive(1'b0, 1'b1, 11'd70, 10'd210, 1'b0, 1'b0);
    idle(1);
    drive(1'b0, 1'b1, 11'd80, 10'd310, 1'b0, 1'b0);
    idle(1);
    drive(1'b1, 1'b0, gun_x, gun_y, 1'b0, 1'b0);
    drive(1'b0, 1'b1, gun_x, gun_y, 1'b0, 1'b0);
    pulse_reset();
    idle(6);
    after_edge();
    check("post_rst_idle_active", active, 0);
    drive(1'b0, 1'b1, 11'd90, 10'd600, 1'b0, 1'b0);
    idle(2);

    // Random traffic.
    repeat (1500) begin
      tk = ($urandom_range(0, 11) == 0);
      fr = ($urandom_range(0, 4) == 0);
      cl = ($urandom_range(0, 199) == 0);
      fc = ($urandom_range(0, 7) == 0);
      drive(tk, fr, 11'($urandom_range(0, 2047)), 10'($urandom_range(0, 1023)), cl, fc);
    end
    idle(20);
    after_edge();
    check("sb_drained", sbq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
